// File: rtl/led_pkg.sv
// Shared definitions for the walking-LED receive-side checker.
// Contents:
//   LED_START / LED_SECOND / LED_BLANK : bus values of interest in the walk
//   POS_BLANK / POS_ILLEGAL            : position codes for "all off" and "multiple lit"
//   led_state_t                        : checker FSM state
//   led_next()                         : value that must follow a given walk step
//   led_pos()                          : lit-position decode of one bus sample
package led_pkg;

    localparam logic [7:0] LED_START   = 8'h80;
    localparam logic [7:0] LED_SECOND  = 8'h40;
    localparam logic [7:0] LED_BLANK   = 8'h00;
    localparam logic [3:0] POS_BLANK   = 4'd8;
    localparam logic [3:0] POS_ILLEGAL = 4'd15;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } led_state_t;

    // The walk shifts right and inserts one blank step before wrapping.
    function automatic logic [7:0] led_next(input logic [7:0] x);
        return (x == LED_BLANK) ? LED_START : (x >> 1);
    endfunction

    // x & (x-1) clears the lowest set bit, so non-zero means two or more bits lit.
    function automatic logic [3:0] led_pos(input logic [7:0] x);
        logic [3:0] p;
        p = POS_BLANK;
        if (x == LED_BLANK) begin
            p = POS_BLANK;
        end else if ((x & (x - 8'd1)) != LED_BLANK) begin
            p = POS_ILLEGAL;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (x[i]) p = 4'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/led_sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk      : clock
//   i_clear  : synchronous clear, wins over i_inc
//   i_inc    : count one event this cycle; ignored once the count is all-ones
//   o_count  : current count
module led_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/led_walk_checker.sv
// Receive-side checker for the walking-LED shifter. Each enabled sample of
// the LED bus is decoded to a lit position and fed to a lock FSM that follows
// the 9-step walk 80,40,20,10,08,04,02,01,00. Once locked, completed sweeps
// and sequence violations are counted.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   i_led_in       : LED bus under test (already in the clk domain)
//   i_sample_en    : take i_led_in as one walk step this cycle
//   o_pos          : decoded position of the last sample (8 = blank, 15 = illegal)
//   o_pos_valid    : one-cycle pulse, registered copy of i_sample_en
//   o_locked       : lock declared and sequence being tracked
//   o_err_pulse    : one-cycle pulse on a violation while locked
//   o_sweep_cnt    : completed sweeps while locked (saturating)
//   o_err_cnt      : violations while locked (saturating)
//   o_state        : FSM state, for observation
module led_walk_checker
    import led_pkg::*;
#(
    parameter int LOCK_LEN = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       i_led_in,
    input  logic             i_sample_en,
    output logic [3:0]       o_pos,
    output logic             o_pos_valid,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic [CNT_W-1:0] o_sweep_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output led_state_t       o_state
);

    localparam logic [3:0] LOCK_LEN_W = 4'(LOCK_LEN);

    led_state_t r_state;
    logic [7:0] r_expect;
    logic [3:0] r_run;
    logic [3:0] r_pos;
    logic       r_pos_valid;
    logic       r_locked;
    logic       r_err_pulse;

    logic w_match;
    logic w_sample_locked;
    logic w_sweep_inc;
    logic w_err_inc;

    assign w_match         = (i_led_in == r_expect);
    assign w_sample_locked = i_sample_en && (r_state == LOCKED);
    // A sweep completes on a correct blank step while locked.
    assign w_sweep_inc     = w_sample_locked && w_match && (i_led_in == LED_BLANK);
    assign w_err_inc       = w_sample_locked && !w_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HUNT;
            r_expect    <= LED_START;
            r_run       <= 4'd0;
            r_pos       <= 4'd0;
            r_pos_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_pos_valid <= i_sample_en;
            r_err_pulse <= 1'b0;
            if (i_sample_en) begin
                r_pos <= led_pos(i_led_in);
                case (r_state)
                    HUNT: begin
                        if (i_led_in == LED_START) begin
                            r_run    <= 4'd1;
                            r_expect <= LED_SECOND;
                            if (LOCK_LEN == 1) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end else begin
                                r_state <= TRACK;
                            end
                        end
                    end
                    TRACK: begin
                        if (w_match) begin
                            r_run    <= r_run + 4'd1;
                            r_expect <= led_next(i_led_in);
                            if ((r_run + 4'd1) == LOCK_LEN_W) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else if (i_led_in == LED_START) begin
                            // A fresh start re-arms the run without an error.
                            r_run    <= 4'd1;
                            r_expect <= LED_SECOND;
                        end else begin
                            r_state  <= HUNT;
                            r_run    <= 4'd0;
                            r_expect <= LED_START;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            r_expect <= led_next(i_led_in);
                        end else begin
                            r_err_pulse <= 1'b1;
                            if (i_led_in == LED_START) begin
                                r_run    <= 4'd1;
                                r_expect <= LED_SECOND;
                                if (LOCK_LEN == 1) begin
                                    r_state  <= LOCKED;
                                    r_locked <= 1'b1;
                                end else begin
                                    r_state  <= TRACK;
                                    r_locked <= 1'b0;
                                end
                            end else begin
                                r_state  <= HUNT;
                                r_locked <= 1'b0;
                                r_run    <= 4'd0;
                                r_expect <= LED_START;
                            end
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                        r_run    <= 4'd0;
                        r_expect <= LED_START;
                    end
                endcase
            end
        end
    end

    led_sat_counter #(.W(CNT_W)) u_sweep_cnt (
        .clk     (clk),
        .i_clear (reset),
        .i_inc   (w_sweep_inc),
        .o_count (o_sweep_cnt)
    );

    led_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .i_clear (reset),
        .i_inc   (w_err_inc),
        .o_count (o_err_cnt)
    );

    assign o_pos       = r_pos;
    assign o_pos_valid = r_pos_valid;
    assign o_locked    = r_locked;
    assign o_err_pulse = r_err_pulse;
    assign o_state     = r_state;

endmodule

// File: doc/led_walk_checker.md
Name: led_walk_checker

Overview:
- Receive-side companion to the walking-LED shifter.
- Samples the 8-bit LED bus, decodes the lit position and locks onto the 9-step walking sequence.
- The walking sequence is 0x80, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02, 0x01, 0x00, then it wraps to 0x80.
- Reports sequence errors and completed sweeps, for board self-test and loopback checking of the LED driver.

Parameters:
- LOCK_LEN, 3: consecutive correct samples, starting with 0x80, needed to declare lock. Legal range 1..9.
- CNT_W, 16: width of the sweep and error counters. Both counters saturate.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- led_in  in  8  LED bus under test, already synchronous to clk
- sample_en  in  1  when high, led_in is taken as one sequence step this cycle
- pos  out  4  decoded position of the last sample
- pos_valid  out  1  one-cycle pulse, registered copy of sample_en
- locked  out  1  high while tracking the sequence with lock declared
- err_pulse  out  1  one-cycle pulse on a sequence violation while locked
- sweep_cnt  out  CNT_W  completed sweeps while locked
- err_cnt  out  CNT_W  violations while locked

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=HUNT, pos=0, pos_valid=0, locked=0, err_pulse=0, sweep_cnt=0, err_cnt=0.
  - Internal expect register=0x80, run counter=0.
  - Reset mid-sequence discards all tracking; the next lock must start again from 0x80.
- Cycles with sample_en=0:
  - All state is held.
  - pos_valid and err_pulse are 0.
- pos decode, registered, 1-cycle latency from the sample_en cycle:
  - exactly one bit set: pos = bit index (0x80 gives 7, 0x01 gives 0)
  - 0x00: pos = 8
  - more than one bit set: pos = 15
- Next-expected function: next(x) = 0x80 if x==0x00, else x>>1.
- State machine, evaluated only on sample_en=1 cycles:
  - HUNT:
    - led_in==0x80: run=1, expect=0x40. Go to LOCKED if LOCK_LEN==1, else go to TRACK.
    - Any other value: stay in HUNT.
  - TRACK:
    - led_in==expect: run++, expect=next(led_in). When run reaches LOCK_LEN, go to LOCKED and assert locked from the next cycle.
    - Mismatch with led_in==0x80: re-arm with run=1, expect=0x40, stay in TRACK. No error is reported.
    - Other mismatch: go to HUNT. No error is reported.
  - LOCKED:
    - led_in==expect: expect=next(led_in).
    - If that correct sample is 0x00, sweep_cnt++ (saturating at all-ones).
    - Mismatch: err_pulse=1 for one cycle and err_cnt++ (saturating). locked drops on the next cycle.
    - If the mismatched value is 0x80: run=1, expect=0x40, go to TRACK (or directly to LOCKED if LOCK_LEN==1, in which case locked stays high).
    - Any other mismatched value: go to HUNT.
- Simultaneous events: saturation suppresses only the increment. err_pulse still fires.
- pos_valid, pos, err_pulse and the counters all update on the same clk edge following the sample.
- Counters are never cleared except by reset.

Decomposition:
- Shared package led_pkg:
  - constants LED_START=8'h80, LED_BLANK=8'h00, POS_BLANK=4'd8, POS_ILLEGAL=4'd15
  - state enum {HUNT, TRACK, LOCKED}
  - function led_next(x)
  - function led_pos(x)
- One natural sub-module: led_sat_counter (parameter W; inputs inc and clear), instantiated twice, once for sweep_cnt and once for err_cnt.

Test Plan:
1. Clean stream, LOCK_LEN=3: drive the 9-step sequence continuously with sample_en=1 every cycle. Expected response:
   - locked rises on the cycle after the third sample (0x20).
   - sweep_cnt=2 after two full sweeps.
   - err_cnt=0.
   - pos sequence is 7,6,5,4,3,2,1,0,8 repeating.
2. Sparse sampling: same stream with sample_en high one cycle in four, and led_in garbage (0xFF) between samples. Expected: identical lock and count results as scenario 1, since only sampled cycles matter.
3. Skipped step while locked: the stream jumps 0x10 to 0x04. Expected response:
   - one err_pulse.
   - err_cnt=1.
   - locked falls on the following cycle; state returns to HUNT.
   - relock happens on the next 0x80 plus two correct samples.
4. Mismatch on 0x80 while locked: 0x08 followed by 0x80. Expected response:
   - err_cnt=1.
   - goes to TRACK with run=1.
   - locked is back after 0x40 and 0x20.
   - illegal input 0x81 yields pos=15.
5. Saturation: CNT_W=2, run 5 clean sweeps. Expected: sweep_cnt holds 3, then one injected error gives err_cnt=1.
6. Reset mid-sweep while locked at expect=0x08. Expected:
   - next cycle: all outputs are 0 and locked=0.
   - feeding 0x08 does not lock; lock requires a fresh 0x80.
